// File: rtl/mag_pkg.sv
// Shared types and default sizing for the magnitude window statistics block.
package mag_pkg;

    localparam int MAG_DATA_W   = 8;
    localparam int MAG_LOG2_WIN = 3;
    localparam int WIN          = 1 << MAG_LOG2_WIN;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

endpackage

// File: rtl/mag_window_acc.sv
// Per-window accumulators (sum, peak, over-threshold count, sample count).
// Exposes the post-update values so the window-closing sample is included in the result.
module mag_window_acc
    import mag_pkg::*;
#(
    parameter int DATA_W   = MAG_DATA_W,
    parameter int LOG2_WIN = MAG_LOG2_WIN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       accept_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [DATA_W-1:0]          thresh_i,
    output logic [DATA_W+LOG2_WIN-1:0] sum_upd_o,
    output logic [DATA_W-1:0]          peak_upd_o,
    output logic [LOG2_WIN:0]          over_upd_o,
    output logic                       last_o
);

    localparam int SUM_W = DATA_W + LOG2_WIN;

    logic [SUM_W-1:0]    sum_q,  sum_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic [LOG2_WIN:0]   over_q, over_d;
    logic [LOG2_WIN-1:0] cnt_q,  cnt_d;

    assign sum_upd_o  = sum_q + SUM_W'(data_i);
    assign peak_upd_o = (data_i > peak_q) ? data_i : peak_q;
    assign over_upd_o = over_q + (LOG2_WIN + 1)'(data_i > thresh_i);
    // cnt saturates at all-ones exactly when W-1 samples have been taken
    assign last_o     = accept_i && (&cnt_q);

    always_comb begin
        sum_d  = sum_q;
        peak_d = peak_q;
        over_d = over_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sum_d  = '0;
            peak_d = '0;
            over_d = '0;
            cnt_d  = '0;
        end else if (accept_i) begin
            sum_d  = sum_upd_o;
            peak_d = peak_upd_o;
            over_d = over_upd_o;
            cnt_d  = cnt_q + LOG2_WIN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            peak_q <= '0;
            over_q <= '0;
            cnt_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            peak_q <= peak_d;
            over_q <= over_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mag_window_stats.sv
// Windowed average/peak/over-threshold statistics over a valid/ready magnitude stream.
// Optional build macro MAG_WINDOW_STATS_ROUND_EN selects round-half-up averaging.
module mag_window_stats
    import mag_pkg::*;
#(
    parameter int DATA_W   = MAG_DATA_W,
    parameter int LOG2_WIN = MAG_LOG2_WIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   cfg_thresh,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_avg,
    output logic [DATA_W-1:0]   out_peak,
    output logic [LOG2_WIN:0]   out_over
);

    localparam int SUM_W = DATA_W + LOG2_WIN;

    state_e state_q, state_d;

    logic                accept;
    logic                clear;
    logic                last;
    logic [SUM_W-1:0]    sum_upd;
    logic [DATA_W-1:0]   peak_upd;
    logic [LOG2_WIN:0]   over_upd;
    logic [DATA_W-1:0]   avg_next;

    logic [DATA_W-1:0]   avg_q;
    logic [DATA_W-1:0]   peak_q;
    logic [LOG2_WIN:0]   over_q;

    assign accept = in_valid && in_ready;

    mag_window_acc #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .accept_i   (accept),
        .data_i     (in_data),
        .thresh_i   (cfg_thresh),
        .sum_upd_o  (sum_upd),
        .peak_upd_o (peak_upd),
        .over_upd_o (over_upd),
        .last_o     (last)
    );

`ifdef MAG_WINDOW_STATS_ROUND_EN
    localparam int HALF = 1 << (LOG2_WIN - 1);
    logic [SUM_W:0] sum_rnd;
    // max sum + W/2 stays below 2^DATA_W * W, so the shifted result always fits
    assign sum_rnd  = {1'b0, sum_upd} + (SUM_W + 1)'(HALF);
    assign avg_next = DATA_W'(sum_rnd >> LOG2_WIN);
`else
    assign avg_next = DATA_W'(sum_upd >> LOG2_WIN);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last)      state_d = EMIT;
            EMIT:    if (out_ready) state_d = ACCUM;
            default:                state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == EMIT);
        clear     = (state_q == EMIT) && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_q  <= '0;
            peak_q <= '0;
            over_q <= '0;
        end else if (last) begin
            avg_q  <= avg_next;
            peak_q <= peak_upd;
            over_q <= over_upd;
        end
    end

    assign out_avg  = avg_q;
    assign out_peak = peak_q;
    assign out_over = over_q;

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed scoreboard bench for mag_window_stats (default sizing, W = 8).
module tb_mag_window_stats;

    localparam int DATA_W   = 8;
    localparam int LOG2_WIN = 3;
    localparam int WIN      = 1 << LOG2_WIN;

    typedef struct {
        int avg;
        int peak;
        int over;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic [DATA_W-1:0]   cfg_thresh;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_avg;
    logic [DATA_W-1:0]   out_peak;
    logic [LOG2_WIN:0]   out_over;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e_mon;
    int   s[WIN];
    int   w;

    mag_window_stats #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_avg    (out_avg),
        .out_peak   (out_peak),
        .out_over   (out_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: window statistics computed from the sample list
    task automatic push_expected(input int smp[WIN], input int th);
        exp_t e;
        int   sum;
        sum    = 0;
        e.peak = 0;
        e.over = 0;
        for (int i = 0; i < WIN; i++) begin
            sum += smp[i];
            if (smp[i] > e.peak) e.peak = smp[i];
            if (smp[i] > th) e.over++;
        end
`ifdef MAG_WINDOW_STATS_ROUND_EN
        e.avg = (sum + WIN / 2) / WIN;
`else
        e.avg = sum / WIN;
`endif
        sb.push_back(e);
    endtask

    task automatic send(input int d, output int waited);
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_assert++;
            n_fail++;
            $display("FAIL send_timeout: in_ready observed 0 for %0d cycles, required 1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_result: observed avg %0d with empty scoreboard, required none", out_avg);
            end else begin
                e_mon = sb.pop_front();
                check("avg",  32'(out_avg),  32'(e_mon.avg));
                check("peak", 32'(out_peak), 32'(e_mon.peak));
                check("over", 32'(out_over), 32'(e_mon.over));
                $display("window result avg=%0d peak=%0d over=%0d", out_avg, out_peak, out_over);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'd99;
        cfg_thresh = 8'd50;
        out_ready  = 1'b1;

        // Reset with a sample offered: nothing may be counted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_valid",     32'(out_valid), 32'd0);
        check("rst_avg",       32'(out_avg),   32'd0);
        check("rst_peak",      32'(out_peak),  32'd0);
        check("rst_over",      32'(out_over),  32'd0);
        @(posedge clk);
        #1;

        // Basic window 10..80, thresh 50
        for (int i = 0; i < WIN; i++) s[i] = 10 * (i + 1);
        push_expected(s, 50);
        for (int i = 0; i < WIN; i++) send(s[i], w);
        @(negedge clk);
        check("basic_valid_hi", 32'(out_valid), 32'd1);
        check("basic_ready_lo", 32'(in_ready),  32'd0);
        @(negedge clk);
        check("basic_valid_1cyc", 32'(out_valid), 32'd0);
        check("basic_next_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Backpressure: result held while out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < WIN; i++) s[i] = 30;
        push_expected(s, 50);
        for (int i = 0; i < WIN; i++) send(30, w);
        in_valid = 1'b1;
        in_data  = 8'd200;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            check("bp_avg",      32'(out_avg),   32'd30);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < WIN; i++) s[i] = 200;
        push_expected(s, 50);
        send(200, w);
        check("bp_first_accept_wait", 32'(w), 32'd1);
        for (int i = 1; i < WIN; i++) send(200, w);
        @(posedge clk);
        #1;

        // Gapped input, thresh 100
        cfg_thresh = 8'd100;
        for (int i = 0; i < WIN; i++) s[i] = 100;
        push_expected(s, 100);
        for (int i = 0; i < WIN; i++) begin
            send(100, w);
            @(negedge clk);
            check("gap_valid", 32'(out_valid), (i == WIN - 1) ? 32'd1 : 32'd0);
            repeat (3) @(posedge clk);
            #1;
        end

        // Reset mid-window discards the partial window
        cfg_thresh = 8'd0;
        for (int i = 0; i < 4; i++) send(7, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < WIN; i++) s[i] = 255;
        push_expected(s, 0);
        for (int i = 0; i < WIN; i++) send(255, w);
        @(posedge clk);
        #1;

        // Reset during EMIT loses the pending result
        out_ready = 1'b0;
        for (int i = 0; i < WIN; i++) send(5, w);
        @(negedge clk);
        check("emit_rst_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("emit_rst_valid", 32'(out_valid), 32'd0);
        check("emit_rst_avg",   32'(out_avg),   32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Rounding boundary: sum 4 over 8 samples
        for (int i = 0; i < WIN; i++) s[i] = (i == 0) ? 4 : 0;
        push_expected(s, 0);
        for (int i = 0; i < WIN; i++) send(s[i], w);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mag_window_stats.md
# mag_window_stats

Downstream consumer of the vector-magnitude stage. It accepts the 8-bit magnitude results over a valid/ready handshake and collects them into fixed windows of 2^LOG2_WIN samples. At the end of each window it reports the average, the peak, and the count of samples above a programmable threshold. The result is held on a valid/ready output port until the output-side consumer accepts it.

## Interface
Parameters:
- DATA_W, 8, magnitude sample width
- LOG2_WIN, 3, log2 of window length (window W = 2^LOG2_WIN, legal 1..6)

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  magnitude sample present
- in_data  in  DATA_W  magnitude sample
- in_ready  out  1  block can accept a sample
- cfg_thresh  in  DATA_W  over-threshold compare level; live, sampled per accepted sample
- out_valid  out  1  window result present
- out_ready  in  1  consumer accepts result
- out_avg  out  DATA_W  window average
- out_peak  out  DATA_W  window maximum
- out_over  out  LOG2_WIN+1  samples in window strictly greater than cfg_thresh

## Operation
- Two-state FSM: ACCUM, EMIT. Reset state is ACCUM.
- ACCUM behaviour:
  - in_ready=1.
  - Each handshake (in_valid && in_ready) does the following:
    - sum += in_data; sum is DATA_W+LOG2_WIN bits wide and cannot overflow.
    - peak = max(peak, in_data).
    - over += (in_data > cfg_thresh).
    - cnt += 1.
  - Cycles without a handshake change nothing.
- Window close: the handshake that occurs with cnt == W-1 loads the output registers from the updated values and moves the FSM to EMIT.
  - out_avg = sum_final >> LOG2_WIN (truncate).
  - out_peak and out_over take their final values.
- EMIT behaviour:
  - in_ready=0, out_valid=1.
  - Outputs are held stable until out_ready=1.
  - On the out_ready handshake: sum/peak/over/cnt clear to 0 and the FSM returns to ACCUM.
- in_ready is a pure function of state; it has no combinational path from out_ready.
- The block drops no samples. Upstream must hold in_valid/in_data until in_ready.

## Timing
- Reset values:
  - in_ready=1 (from the first cycle after reset is deasserted).
  - out_valid=0, out_avg=0, out_peak=0, out_over=0.
  - Internal sum, peak, over and cnt are all 0.
- Latency: out_valid rises on the cycle after the W-th accepted sample.
- Throughput: with out_ready tied high, one window every W+1 cycles minimum.
  - Example: W=8 gives 8 accept cycles plus 1 EMIT cycle.
  - This rate exceeds the upstream sqrt stage rate (one result per ~9 cycles).
- Minimum EMIT dwell is 1 cycle: EMIT→ACCUM occurs on the same edge that out_ready is sampled high.
- rst mid-window: the partial window is discarded and the next window starts with cnt=0.
- rst during EMIT: the pending result is lost and out_valid=0 on the next cycle.
- A cfg_thresh change mid-window affects only samples accepted after the change.
- Peak ties: a value equal to the current peak leaves it unchanged (no visible effect).

## Configuration
- MAG_WINDOW_STATS_ROUND_EN:
  - Defined: out_avg = (sum + 2^(LOG2_WIN-1)) >> LOG2_WIN, i.e. round-half-up. The result cannot exceed 2^DATA_W-1, since max sum + W/2 < 2^DATA_W·W, so no saturation logic is needed.
  - Undefined: truncating shift.
  - All other behaviour is identical in both builds.

## Structure
- Shared package mag_pkg holds:
  - FSM state enum (ACCUM, EMIT).
  - Default DATA_W / LOG2_WIN constants.
  - A helper constant WIN = 1 << LOG2_WIN.
- One sub-module: mag_window_acc.
  - Contains sum, peak, over and cnt, with clear and accept inputs.
  - Exposes a last output (cnt == W-1 && accept).
- The top level holds the FSM, the output registers and the avg shift/round.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → in_ready=1, out_valid=0, all outputs 0; no sample is counted during reset.
- Basic window:
  - Stimulus: W=8, cfg_thresh=50, samples 10,20,…,80 back-to-back, out_ready=1.
  - Response: out_valid for exactly 1 cycle, one cycle after sample 80; out_avg=45, out_peak=80, out_over=3.
  - Next window accepts on the following cycle.
- Backpressure:
  - Stimulus: after a window closes, hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: outputs stable, in_ready=0, no sample consumed; after the out_ready handshake the first sample is accepted the next cycle.
- Gapped input:
  - Stimulus: 8 samples of 100, each separated by 3 idle cycles, cfg_thresh=100.
  - Response: out_avg=100, out_peak=100, out_over=0; out_valid asserts only after the 8th handshake.
- Reset mid-window:
  - Stimulus: 4 samples of 7, rst pulse, then 8 samples of 255.
  - Response: out_avg=255, out_peak=255, out_over=8 (cfg_thresh=0).
- Rounding: samples 4,0,0,0,0,0,0,0 (sum 4) → out_avg=0 without MAG_WINDOW_STATS_ROUND_EN, out_avg=1 with it.
